// File: rtl/johnson_pkg.sv
// johnson_pkg: shared legality check, popcount-based index mapping and index-width helper for the Johnson counter
package johnson_pkg;
  localparam int MAX_W = 32;
  function automatic int idx_width(input int w);
    return $clog2(2 * w);
  endfunction
  function automatic logic is_johnson(input logic [MAX_W-1:0] v, input int w);
    int n;
    n = 0;
    for (int i = 0; i < MAX_W - 1; i++)
      if (i < w - 1 && v[i] != v[i+1]) n++;
    return n <= 1;
  endfunction
  function automatic int johnson_index(input logic [MAX_W-1:0] v, input int w);
    int p;
    p = 0;
    for (int i = 0; i < MAX_W; i++) p += int'(v[i]);
    return v == '0 ? 0 : v[0] ? p : 2 * w - p;
  endfunction
endpackage

// File: rtl/johnson_decode.sv
// johnson_decode: combinational decode of a ring value q into idx, one-hot dec, terminal count tc and illegal flag
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = idx_width(WIDTH),
  localparam int N = 2 * WIDTH
) (
  input  logic [WIDTH-1:0] q,
  output logic [IW-1:0]    idx,
  output logic [N-1:0]     dec,
  output logic             tc,
  output logic             illegal
);
  logic legal;
  always_comb begin
    legal = is_johnson(MAX_W'(q), WIDTH);
    illegal = !legal;
    idx = legal ? IW'(johnson_index(MAX_W'(q), WIDTH)) : '0;
    dec = legal ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
    tc = legal && idx == IW'(N - 1);
  end
endmodule

// File: rtl/johnson_counter.sv
// johnson_counter: free-running self-recovering Johnson ring; clk, rst (async active-low) in; q, idx, dec, tc, illegal out
module johnson_counter
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = idx_width(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [WIDTH-1:0]   q,
  output logic [IW-1:0]      idx,
  output logic [2*WIDTH-1:0] dec,
  output logic               tc,
  output logic               illegal
);
  logic [WIDTH-1:0] ring_q, ring_d;
  always_comb ring_d = illegal ? '0 : {ring_q[WIDTH-2:0], ~ring_q[WIDTH-1]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) ring_q <= '0;
    else ring_q <= ring_d;
  assign q = ring_q;
  johnson_decode #(.WIDTH(WIDTH)) u_dec (
    .q(ring_q),
    .idx(idx),
    .dec(dec),
    .tc(tc),
    .illegal(illegal)
  );
endmodule

// File: tb/tb_johnson_counter.sv
// tb_johnson_counter: directed self-checking bench for johnson_counter at WIDTH=4 and WIDTH=3
module tb_johnson_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] q4;
  logic [2:0] idx4;
  logic [7:0] dec4;
  logic tc4, il4;
  logic [2:0] q3;
  logic [2:0] idx3;
  logic [5:0] dec3;
  logic tc3, il3;
  int errs = 0;
  int checks = 0;
  logic [3:0] seq4 [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [2:0] seq3 [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
  always #5 clk = ~clk;
  johnson_counter #(.WIDTH(4)) d4 (
    .clk(clk), .rst(rst), .q(q4), .idx(idx4), .dec(dec4), .tc(tc4), .illegal(il4)
  );
  johnson_counter #(.WIDTH(3)) d3 (
    .clk(clk), .rst(rst), .q(q3), .idx(idx3), .dec(dec3), .tc(tc3), .illegal(il3)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    tick;
    tick;
    chk("rst.q4", 32'(q4), 32'h0);
    chk("rst.idx4", 32'(idx4), 32'h0);
    chk("rst.dec4", 32'(dec4), 32'h1);
    chk("rst.tc4", 32'(tc4), 32'h0);
    chk("rst.il4", 32'(il4), 32'h0);
    chk("rst.q3", 32'(q3), 32'h0);
    chk("rst.dec3", 32'(dec3), 32'h1);
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick;
      chk("seq4.q", 32'(q4), 32'(seq4[k % 8]));
      chk("seq4.idx", 32'(idx4), 32'(k % 8));
      chk("seq4.dec", 32'(dec4), 32'(1) << (k % 8));
      chk("seq4.tc", 32'(tc4), 32'(k % 8 == 7));
      chk("seq4.il", 32'(il4), 32'h0);
      chk("seq3.q", 32'(q3), 32'(seq3[k % 6]));
      chk("seq3.idx", 32'(idx3), 32'(k % 6));
      chk("seq3.dec", 32'(dec3), 32'(1) << (k % 6));
      chk("seq3.tc", 32'(tc3), 32'(k % 6 == 5));
      chk("seq3.il", 32'(il3), 32'h0);
    end
    tick;
    chk("pre_rst.q4", 32'(q4), 32'hE);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.q4", 32'(q4), 32'h0);
    chk("async_rst.idx4", 32'(idx4), 32'h0);
    chk("async_rst.dec4", 32'(dec4), 32'h1);
    chk("async_rst.q3", 32'(q3), 32'h0);
    tick;
    chk("held_rst.q4", 32'(q4), 32'h0);
    rst = 1'b1;
    tick;
    chk("restart.q4", 32'(q4), 32'h1);
    chk("restart.q3", 32'(q3), 32'h1);
    force d4.ring_q = 4'b0101;
    #1;
    chk("ill0101.q", 32'(q4), 32'h5);
    chk("ill0101.il", 32'(il4), 32'h1);
    chk("ill0101.dec", 32'(dec4), 32'h0);
    chk("ill0101.idx", 32'(idx4), 32'h0);
    chk("ill0101.tc", 32'(tc4), 32'h0);
    release d4.ring_q;
    tick;
    chk("rec0101.q", 32'(q4), 32'h0);
    chk("rec0101.il", 32'(il4), 32'h0);
    tick;
    chk("rec0101.q2", 32'(q4), 32'h1);
    force d4.ring_q = 4'b1001;
    #1;
    chk("ill1001.il", 32'(il4), 32'h1);
    chk("ill1001.dec", 32'(dec4), 32'h0);
    chk("ill1001.idx", 32'(idx4), 32'h0);
    release d4.ring_q;
    tick;
    chk("rec1001.q", 32'(q4), 32'h0);
    tick;
    chk("rec1001.q2", 32'(q4), 32'h1);
    chk("rec1001.il", 32'(il4), 32'h0);
    force d4.ring_q = 4'b0110;
    #1;
    chk("ill0110.il", 32'(il4), 32'h1);
    chk("ill0110.dec", 32'(dec4), 32'h0);
    chk("ill0110.idx", 32'(idx4), 32'h0);
    release d4.ring_q;
    tick;
    chk("rec0110.q", 32'(q4), 32'h0);
    tick;
    chk("rec0110.q2", 32'(q4), 32'h1);
    chk("rec0110.il", 32'(il4), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/johnson_counter.md
Name: johnson_counter

Overview:
- Free-running, parameterised Johnson (twisted-ring) counter with 2*WIDTH states.
- Used as a glitch-free sequence and phase generator.
- Alongside the raw ring value it provides a decoded state index, a one-hot phase decode, a terminal-count strobe and an illegal-state flag.
- It recovers automatically from corrupted (non-Johnson) states.

Parameters:
- WIDTH, 4, ring length in flops; must be >= 2; the sequence length is 2*WIDTH.
- IW, $clog2(2*WIDTH), derived (localparam): width of idx.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst  input  1  asynchronous, active-low reset; asserts immediately, deassertion is synchronised by the system.
- q  output  WIDTH  registered Johnson ring value.
- idx  output  IW  state index 0..2*WIDTH-1, combinational from q.
- dec  output  2*WIDTH  one-hot phase decode; dec[idx]=1.
- tc  output  1  terminal count: high in the last state before wrap.
- illegal  output  1  high while q is not a legal Johnson code word.

Behaviour:
- Reset: while rst=0, q=0 asynchronously. Consequently idx=0, dec=1 (bit 0 set), tc=0, illegal=0.
- Advance: on every rising clk edge with rst=1, q <= {q[WIDTH-2:0], ~q[WIDTH-1]}. There is no enable input; the counter advances every cycle.
- Sequence for WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000. Period is 8 cycles.
- Legal code word: at most one position i in 0..WIDTH-2 where q[i] != q[i+1]. All 2*WIDTH sequence values satisfy this; every other value is illegal.
- Recovery: if q is illegal at a rising edge, next q = 0 instead of the shift. A corrupted state therefore returns to the sequence in exactly one cycle.
- idx (legal states only), with p = popcount(q):
  - q == 0: idx = 0.
  - q[0] == 1: idx = p.
  - otherwise: idx = 2*WIDTH - p.
- Worked WIDTH=4 values: 1111 -> 4, 1110 -> 5, 1000 -> 7.
- Illegal state: idx = 0, dec = 0, illegal = 1.
- dec is one-hot of idx when legal and all zeros when illegal.
- tc = 1 iff q is legal and idx == 2*WIDTH-1 (q = 1 followed by WIDTH-1 zeros). It is high for exactly one cycle per period, the cycle before q returns to 0.
- idx, dec, tc and illegal are purely combinational from the q register. They have zero latency relative to q and no extra flops.
- Reset asserted mid-sequence forces q=0 immediately, with no wait for a clock edge. The first post-release edge yields q = 0...01.
- Only q is registered; every output is defined in every cycle.

Decomposition:
- Shared package johnson_pkg:
  - function is_johnson(q), the legality check;
  - function johnson_index(q), the popcount-based mapping;
  - the IW computation helper.
- One natural sub-module: johnson_decode. It is purely combinational, takes q as input and produces idx, dec, tc and illegal. The top module holds only the ring register and the recovery mux.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> q=0000, idx=0, dec=00000001, tc=0, illegal=0. Assert rst=0 mid-cycle -> q=0000 before the next edge.
- Full sequence: release rst, run 20 cycles -> q follows 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 repeating, idx counts 1..7 then 0, period 8.
- Terminal count: over 20 cycles, tc is high only when q=1000 (idx=7), exactly once per 8 cycles, and the next q is 0000.
- Illegal recovery: force q=0101 for one edge then release -> illegal=1, dec=0, idx=0 during the forced cycle. Next q=0000, then 0001; illegal=0 afterwards. Repeat with q=1001 and q=0110.
- Reset mid-operation: reset at q=1110 -> q=0000 asynchronously; after release the sequence restarts at 0001.
- Parameter check, WIDTH=3: period 6 with sequence 000, 001, 011, 111, 110, 100. tc at 100. idx and dec cover 0..5 with one-hot dec in all six states.
